// File: rtl/reg_val_arb.sv
// Two-requester load arbiter for a value register: registered IDLE/LOAD/GAP FSM.
// Define REG_VAL_ARB_FIXED_PRIO_EN to make req0 win every tie; the default is round-robin.
module reg_val_arb #(
    parameter int unsigned DATA_W   = 9,
    parameter int unsigned HOLD_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              load,
    output logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic [7:0]        load_cnt
);

    typedef enum logic [1:0] {StIdle, StLoad, StGap} state_t;

    state_t     state_q;
    logic [3:0] gap_cnt_q;
    logic       pick1;

`ifdef REG_VAL_ARB_FIXED_PRIO_EN
    assign pick1 = req1 & ~req0;
`else
    // High when requester 1 was granted most recently; reset makes req0 win the first tie.
    logic last1_q;

    assign pick1 = req1 & (~req0 | ~last1_q);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gap_cnt_q <= 4'd0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            load      <= 1'b0;
            data_in   <= '0;
            busy      <= 1'b0;
            load_cnt  <= 8'd0;
`ifndef REG_VAL_ARB_FIXED_PRIO_EN
            last1_q   <= 1'b1;
`endif
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            load <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req0 || req1) begin
                        state_q <= StLoad;
                        load    <= 1'b1;
                        busy    <= 1'b1;
                        gnt0    <= ~pick1;
                        gnt1    <= pick1;
                        data_in <= pick1 ? data1 : data0;
`ifndef REG_VAL_ARB_FIXED_PRIO_EN
                        last1_q <= pick1;
`endif
                    end
                end
                StLoad: begin
                    load_cnt <= load_cnt + 8'd1;
                    if (HOLD_CYC > 0) begin
                        state_q   <= StGap;
                        gap_cnt_q <= 4'(HOLD_CYC);
                    end else begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
                StGap: begin
                    // Requests are deliberately not looked at until IDLE is re-entered.
                    if (gap_cnt_q <= 4'd1) begin
                        state_q   <= StIdle;
                        gap_cnt_q <= 4'd0;
                        busy      <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    gap_cnt_q <= 4'd0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_val_arb.sv
// Directed bench for reg_val_arb: one instance with HOLD_CYC=2, one with HOLD_CYC=0,
// and a behavioural value register fed from the default instance.
module tb_reg_val_arb;

    localparam int unsigned DW = 9;

    logic          clk;
    logic          rst_n;
    logic          req0, req1;
    logic [DW-1:0] data0, data1;
    logic          gnt0, gnt1, load, busy;
    logic [DW-1:0] data_in;
    logic [7:0]    load_cnt;

    logic          req0_z;
    logic [DW-1:0] data0_z;
    logic          gnt0_z, gnt1_z, load_z, busy_z;
    logic [DW-1:0] data_in_z;
    logic [7:0]    load_cnt_z;

    logic [DW-1:0] reg_val;
    int            checks = 0;
    int            passes = 0;
    int            mon_both = 0;
    int            mon_load = 0;
    int            nloads;
    logic          exp0;

    reg_val_arb #(.DATA_W(DW), .HOLD_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .load(load), .data_in(data_in),
        .busy(busy), .load_cnt(load_cnt)
    );

    reg_val_arb #(.DATA_W(DW), .HOLD_CYC(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0_z), .data0(data0_z), .req1(1'b0), .data1('0),
        .gnt0(gnt0_z), .gnt1(gnt1_z), .load(load_z), .data_in(data_in_z),
        .busy(busy_z), .load_cnt(load_cnt_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Value register model: captures data_in on the edge after the load strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) reg_val <= '0;
        else if (load) reg_val <= data_in;
    end

    always @(negedge clk) begin
        if ((gnt0 && gnt1) || (gnt0_z && gnt1_z)) mon_both++;
        if ((load !== (gnt0 | gnt1)) || (load_z !== (gnt0_z | gnt1_z))) mon_load++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        req0_z = 1'b0; data0_z = '0;

        // Reset state
        tick();
        chk("rst_load", load, 0);
        chk("rst_gnt", {gnt0, gnt1}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", data_in, 0);
        chk("rst_cnt", load_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Single load from req0
        req0 = 1'b1; data0 = 9'h0A5;
        tick();
        chk("s1_gnt0", gnt0, 1);
        chk("s1_gnt1", gnt1, 0);
        chk("s1_load", load, 1);
        chk("s1_data", data_in, 9'h0A5);
        chk("s1_busy0", busy, 1);
        chk("s1_cnt0", load_cnt, 0);
        req0 = 1'b0;
        tick();
        chk("s1_load_off", load, 0);
        chk("s1_regval", reg_val, 9'h0A5);
        chk("s1_cnt1", load_cnt, 1);
        chk("s1_hold_data", data_in, 9'h0A5);
        chk("s1_busy1", busy, 1);
        tick();
        chk("s1_busy2", busy, 1);
        tick();
        chk("s1_busy3", busy, 0);

        // Both requesting continuously after a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req0 = 1'b1; req1 = 1'b1; data0 = 9'h001; data1 = 9'h1FF;
        for (int k = 0; k < 4; k++) begin
`ifdef REG_VAL_ARB_FIXED_PRIO_EN
            exp0 = 1'b1;
`else
            exp0 = (k % 2 == 0);
`endif
            tick();
            chk($sformatf("alt%0d_gnt0", k), gnt0, exp0);
            chk($sformatf("alt%0d_gnt1", k), gnt1, !exp0);
            chk($sformatf("alt%0d_data", k), data_in, exp0 ? 9'h001 : 9'h1FF);
            for (int j = 0; j < 3; j++) begin
                tick();
                chk($sformatf("alt%0d_noload%0d", k, j), load, 0);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("alt_cnt", load_cnt, 4);

        // req1 raised during GAP waits for IDLE
        req0 = 1'b1; data0 = 9'h033;
        tick();
        chk("gap_gnt0", gnt0, 1);
        req0 = 1'b0;
        tick();
        req1 = 1'b1; data1 = 9'h144;
        tick();
        chk("gap_nogrant", {load, gnt1}, 0);
        tick();
        chk("gap_idle_nogrant", {load, gnt1, busy}, 0);
        tick();
        chk("gap_grant1", {load, gnt1, gnt0}, 3'b110);
        chk("gap_data", data_in, 9'h144);
        req1 = 1'b0;
        tick();
        chk("gap_regval", reg_val, 9'h144);
        repeat (3) tick();

        // HOLD_CYC=0: load every other cycle, busy only in LOAD
        req0_z = 1'b1; data0_z = 9'h055;
        tick();
        chk("h0_load_a", {load_z, busy_z}, 2'b11);
        tick();
        chk("h0_gap_a", {load_z, busy_z}, 2'b00);
        tick();
        chk("h0_load_b", {load_z, gnt0_z}, 2'b11);
        chk("h0_data", data_in_z, 9'h055);
        tick();
        chk("h0_gap_b", {load_z, busy_z}, 2'b00);
        chk("h0_cnt", load_cnt_z, 2);
        req0_z = 1'b0;
        tick();

        // Reset asserted during LOAD aborts it
        req0 = 1'b1; data0 = 9'h1AA;
        tick();
        chk("ra_load", load, 1);
        rst_n = 1'b0;
        #1;
        chk("ra_load_rst", {load, gnt0, gnt1, busy}, 0);
        chk("ra_cnt_rst", load_cnt, 0);
        chk("ra_data_rst", data_in, 0);
        req0 = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("ra_noload%0d", j), {load, busy}, 0);
        end
        chk("ra_cnt_after", load_cnt, 0);

        // 256 loads wrap the counter (HOLD_CYC=0 instance, counter cleared by the reset above)
        nloads = 0;
        req0_z = 1'b1; data0_z = 9'h0F0;
        for (int t = 0; t < 1000 && nloads < 256; t++) begin
            tick();
            if (load_z) nloads++;
        end
        chk("wrap_loads", nloads, 256);
        chk("wrap_cnt255", load_cnt_z, 255);
        req0_z = 1'b0;
        tick();
        chk("wrap_cnt0", load_cnt_z, 0);
        tick();

        chk("never_both_gnt", mon_both, 0);
        chk("load_eq_gnt_or", mon_load, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
